// File: rtl/dadda_pkg.sv
// Shared constants and types for the 16x16 Dadda multiplier datapath.
package dadda_pkg;

  localparam int PROD_W = 32;
  localparam int OPND_W = 16;

  typedef struct packed {
    logic [PROD_W-1:0] row_a;
    logic [PROD_W-1:0] row_b;
  } row_pair_t;

endpackage

// File: rtl/fa.sv
// Full-adder cell composed of two half-adders.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (.a_i(a_i), .b_i(b_i),  .s_o(s0),  .c_o(c0));
  ha u_ha1 (.a_i(s0),  .b_i(ci_i), .s_o(s_o), .c_o(c1));

  assign co_o = c0 | c1;

endmodule

// File: rtl/ha.sv
// Half-adder cell.
module ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/rca_slice.sv
// N-bit ripple-carry adder slice built from fa cells.
module rca_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] s_o,
  output logic         cout_o
);

  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .ci_i(c[i]),
      .s_o (s_o[i]),
      .co_o(c[i+1])
    );
  end

  assign cout_o = c[N];

endmodule

// File: rtl/dadda_cpa_pipe.sv
// Two-stage carry-propagate adder closing the Dadda tree: low slice in stage 1,
// high slice plus low carry in stage 2, valid/ready on both sides.
module dadda_cpa_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH = PROD_W,
  parameter int SPLIT = OPND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] prod,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky
);

  localparam int HI_W = WIDTH - SPLIT;

  // Handshake: a transfer happens on a side in any cycle where valid && ready
  // at the rising edge; valid never waits on ready and data holds while stalled.

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q,    s1_lo_d;
  logic             s1_c_q,     s1_c_d;
  logic [HI_W-1:0]  s1_ahi_q,   s1_ahi_d;
  logic [HI_W-1:0]  s1_bhi_q,   s1_bhi_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] prod_q,     prod_d;
  logic             cout_q,     cout_d;
  logic             ovf_q,      ovf_d;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_c;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_c;

  logic s2_adv;
  logic s1_load;
  logic s1_move;

  rca_slice #(.N(SPLIT)) u_lo (
    .a_i   (row_a[SPLIT-1:0]),
    .b_i   (row_b[SPLIT-1:0]),
    .cin_i (1'b0),
    .s_o   (lo_sum),
    .cout_o(lo_c)
  );

  rca_slice #(.N(HI_W)) u_hi (
    .a_i   (s1_ahi_q),
    .b_i   (s1_bhi_q),
    .cin_i (s1_c_q),
    .s_o   (hi_sum),
    .cout_o(hi_c)
  );

  assign s2_adv  = !s2_valid_q || out_ready;
  // Gated by rst so the upstream never sees a ready while reset is held.
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign s1_load = in_valid && in_ready;
  assign s1_move = s1_valid_q && s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    s2_valid_d = s2_valid_q;
    prod_d     = prod_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;

    if (!s1_valid_q || s2_adv) begin
      s1_valid_d = s1_load;
    end
    if (s1_load) begin
      s1_lo_d  = lo_sum;
      s1_c_d   = lo_c;
      s1_ahi_d = row_a[WIDTH-1:SPLIT];
      s1_bhi_d = row_b[WIDTH-1:SPLIT];
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_move) begin
      prod_d = {hi_sum, s1_lo_q};
      cout_d = hi_c;
      ovf_d  = ovf_q | hi_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
      s2_valid_q <= s2_valid_d;
      prod_q     <= prod_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign prod       = prod_q;
  assign cout       = cout_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_dadda_cpa_pipe.sv
// Directed and randomized bench for dadda_cpa_pipe with a FIFO reference of
// 33-bit sums.
module tb_dadda_cpa_pipe;
  import dadda_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] row_a;
  logic [31:0] row_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] prod;
  logic        cout;
  logic        out_valid;
  logic        out_ready;
  logic        ovf_sticky;

  int checks   = 0;
  int failures = 0;
  int n_in     = 0;
  int n_out    = 0;

  logic [32:0] exp_q[$];

  logic        seen_acc;
  logic        seen_ir;
  logic        seen_ov;
  logic [31:0] seen_prod;
  logic        seen_cout;
  logic        seen_ovf;

  dadda_cpa_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .row_a     (row_a),
    .row_b     (row_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, score any transfers.
  task automatic do_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic ordy);
    logic [32:0] e;
    @(negedge clk);
    in_valid  = v;
    row_a     = a;
    row_b     = b;
    out_ready = ordy;
    #1;
    seen_ir   = in_ready;
    seen_ov   = out_valid;
    seen_prod = prod;
    seen_cout = cout;
    seen_ovf  = ovf_sticky;
    seen_acc  = v && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      check("out_expected", 33'(out_valid), 33'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sum", {cout, prod}, e);
      end
    end
    if (seen_acc) begin
      exp_q.push_back(33'(a) + 33'(b));
      n_in++;
    end
    @(posedge clk);
  endtask

  task automatic latency_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ep, input logic ec,
                              input logic ovf_before, input logic ovf_after);
    do_cycle(1'b1, a, b, 1'b1);
    check({tag, "_acc"}, 33'(seen_acc), 33'(1));
    do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    check({tag, "_ov_c1"}, 33'(seen_ov), 33'(0));
    check({tag, "_ovf_c1"}, 33'(seen_ovf), 33'(ovf_before));
    do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    check({tag, "_ov_c2"}, 33'(seen_ov), 33'(1));
    check({tag, "_prod"}, 33'(seen_prod), 33'(ep));
    check({tag, "_cout"}, 33'(seen_cout), 33'(ec));
    check({tag, "_ovf_c2"}, 33'(seen_ovf), 33'(ovf_after));
    do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    check({tag, "_ov_c3"}, 33'(seen_ov), 33'(0));
  endtask

  initial begin
    row_pair_t pr;
    int acc_cnt;
    int nxt;
    int budget;
    int outs_before;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; row_a = '0; row_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", 33'(in_ready), 33'(0));
    check("rst_out_valid", 33'(out_valid), 33'(0));
    check("rst_prod", 33'(prod), 33'(0));
    check("rst_cout", 33'(cout), 33'(0));
    check("rst_ovf", 33'(ovf_sticky), 33'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 33'(in_ready), 33'(1));

    latency_test("t1", 32'hFFFE0000, 32'h00000001, 32'hFFFE0001, 1'b0, 1'b0, 1'b0);
    latency_test("t2", 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0);
    latency_test("t3", 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
    latency_test("t3b", 32'h12345678, 32'h00000008, 32'h12345680, 1'b0, 1'b1, 1'b1);

    // Backpressure: offer 1,2,3 with the consumer stalled.
    acc_cnt = 0;
    nxt = 1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 32'(nxt), 32'h0, 1'b0);
      if (seen_acc) begin
        acc_cnt++;
        nxt++;
      end
      if (i >= 2) begin
        check("bp_prod_hold", 33'(seen_prod), 33'(1));
        check("bp_ov_hold", 33'(seen_ov), 33'(1));
      end
    end
    check("bp_acc_cnt", 33'(acc_cnt), 33'(2));
    check("bp_in_ready_low", 33'(seen_ir), 33'(0));
    outs_before = n_out;
    for (int i = 0; i < 3; i++) begin
      do_cycle(nxt <= 3, 32'(nxt), 32'h0, 1'b1);
      check("bp_release_ov", 33'(seen_ov), 33'(1));
      check("bp_release_order", 33'(seen_prod), 33'(i + 1));
      if (seen_acc) nxt++;
    end
    check("bp_release_cnt", 33'(n_out - outs_before), 33'(3));
    do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
    check("bp_drained", 33'(seen_ov), 33'(0));

    // Streaming with random consumer stalls.
    acc_cnt = 0;
    budget = 0;
    outs_before = n_out;
    nxt = n_in;
    pr.row_a = $urandom();
    pr.row_b = $urandom();
    while (acc_cnt < 100 && budget < 2000) begin
      do_cycle(1'b1, pr.row_a, pr.row_b, 1'($urandom_range(0, 1)));
      if (seen_acc) begin
        acc_cnt++;
        pr.row_a = $urandom();
        pr.row_b = $urandom();
        if ($urandom_range(0, 3) == 0) pr.row_b = ~pr.row_a;
      end
      budget++;
    end
    check("stream_budget", 33'(acc_cnt), 33'(100));
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
      budget++;
    end
    check("stream_drain_empty", 33'(exp_q.size()), 33'(0));
    check("stream_count", 33'(n_out - outs_before), 33'(n_in - nxt));

    // Reset with both stages occupied.
    do_cycle(1'b1, 32'hAAAA0000, 32'h00005555, 1'b0);
    do_cycle(1'b1, 32'h11112222, 32'h33334444, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_full", 33'(out_valid && !in_ready), 33'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 33'(out_valid), 33'(0));
    check("mid_rst_in_ready", 33'(in_ready), 33'(0));
    check("mid_rst_ovf", 33'(ovf_sticky), 33'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    outs_before = n_out;
    latency_test("t6", 32'h0F0F0F0F, 32'h01010101, 32'h10101010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 32'h0, 32'h0, 1'b1);
      check("t6_no_stale", 33'(seen_ov), 33'(0));
    end
    check("t6_out_cnt", 33'(n_out - outs_before), 33'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
